// File: rtl/serial_pair_feeder_pkg.sv
// ============================================================================
// Module   : serial_pair_feeder_pkg
// Brief    : Shared state encoding and sizing helpers for the serial feeder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package serial_pair_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAPW  = 2'd2
    } state_t;

    localparam int c_gap_w = 4;

    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_pair_feeder_piso_shift2.sv
// ============================================================================
// Module   : piso_shift2
// Brief    : Dual parallel-load shifter emitting MSB-first with first/last marks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module piso_shift2 #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] load_a,
    input  logic [WIDTH-1:0] load_b,
    output logic             a,
    output logic             b,
    output logic             bit_valid,
    output logic             first,
    output logic             last
);

    // The MSB goes straight to the output on load, so idx tracks the next bit.
    localparam logic [IDX_W-1:0] c_idx_next = IDX_W'(WIDTH - 2);

    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [IDX_W-1:0] r_idx;
    logic             r_a;
    logic             r_b;
    logic             r_valid;
    logic             r_first;
    logic             r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_idx   <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else if (load) begin
            r_sh_a  <= load_a;
            r_sh_b  <= load_b;
            r_idx   <= c_idx_next;
            r_a     <= load_a[WIDTH-1];
            r_b     <= load_b[WIDTH-1];
            r_valid <= 1'b1;
            r_first <= 1'b1;
            r_last  <= 1'b0;
        end else if (step) begin
            r_idx   <= r_idx - 1'b1;
            r_a     <= r_sh_a[r_idx];
            r_b     <= r_sh_b[r_idx];
            r_valid <= 1'b1;
            r_first <= 1'b0;
            r_last  <= (r_idx == '0);
        end else begin
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign a         = r_a;
    assign b         = r_b;
    assign bit_valid = r_valid;
    assign first     = r_first;
    assign last      = r_last;

endmodule

`default_nettype wire

// File: rtl/serial_pair_feeder.sv
// ============================================================================
// Module   : serial_pair_feeder
// Brief    : Valid/ready word-pair intake with one-word hold, serialised MSB-first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_pair_feeder
    import serial_pair_feeder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             a,
    output logic             b,
    output logic             bit_valid,
    output logic             first,
    output logic             last,
    output logic             busy
);

    localparam int                 c_idx_w    = idx_width(WIDTH);
    localparam logic [c_gap_w-1:0] c_gap_load = (GAP > 0) ? c_gap_w'(GAP - 1) : '0;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_hold_a;
    logic [WIDTH-1:0]   r_hold_b;
    logic               r_hold_full;
    logic [c_gap_w-1:0] r_gap;
    logic [c_gap_w-1:0] w_gap_next;
    logic               r_busy;
    logic               w_accept;
    logic               w_avail;
    logic               w_load;
    logic               w_step;
    logic               w_hold_fill;
    logic               w_hold_full_next;
    logic               w_last;
    logic [WIDTH-1:0]   w_load_a;
    logic [WIDTH-1:0]   w_load_b;

    assign in_ready = !rst && !r_hold_full;
    assign w_accept = in_valid && in_ready;
    assign w_avail  = r_hold_full || w_accept;
    assign w_load_a = r_hold_full ? r_hold_a : in_a;
    assign w_load_b = r_hold_full ? r_hold_b : in_b;

    always_comb begin
        w_next_state = r_state;
        w_gap_next   = r_gap;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_avail) begin
                    w_load       = 1'b1;
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!w_last) begin
                    w_step = 1'b1;
                end else if (GAP == 0) begin
                    // Chain straight into the next word so no bubble appears.
                    if (w_avail) begin
                        w_load = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_next_state = ST_GAPW;
                    w_gap_next   = c_gap_load;
                end
            end
            ST_GAPW: begin
                if (r_gap == '0) begin
                    if (w_avail) begin
                        w_load       = 1'b1;
                        w_next_state = ST_SHIFT;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_gap_next = r_gap - 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // A word bypasses the hold only when the shifter takes it on the accept edge.
    assign w_hold_fill      = w_accept && !w_load;
    assign w_hold_full_next = (r_hold_full && !w_load) || w_hold_fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gap       <= '0;
            r_hold_a    <= '0;
            r_hold_b    <= '0;
            r_hold_full <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_gap       <= w_gap_next;
            r_hold_full <= w_hold_full_next;
            r_busy      <= (w_next_state != ST_IDLE) || w_hold_full_next;
            if (w_hold_fill) begin
                r_hold_a <= in_a;
                r_hold_b <= in_b;
            end
        end
    end

    piso_shift2 #(
        .WIDTH (WIDTH),
        .IDX_W (c_idx_w)
    ) u_piso (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .step      (w_step),
        .load_a    (w_load_a),
        .load_b    (w_load_b),
        .a         (a),
        .b         (b),
        .bit_valid (bit_valid),
        .first     (first),
        .last      (w_last)
    );

    assign last = w_last;
    assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_serial_pair_feeder.sv
// ============================================================================
// Module   : tb_serial_pair_feeder
// Brief    : Randomised bench for GAP=0 and GAP=2 feeders against a schedule model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_pair_feeder;

    localparam int W = 32;

    typedef struct {
        int         inst;
        logic [W-1:0] wa;
        logic [W-1:0] wb;
        int         acc;
        int         start;
    } sched_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_a      [2];
    logic [W-1:0] in_b      [2];
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic         a         [2];
    logic         b         [2];
    logic         bit_valid [2];
    logic         first     [2];
    logic         last      [2];
    logic         busy      [2];

    sched_t       sq [$];
    logic [63:0]  src [$];
    int           cur [2];
    int           prev_end [2];
    int           t;
    int           n_tests;
    int           n_fail;

    always #5 clk = ~clk;

    serial_pair_feeder #(.WIDTH(W), .GAP(0)) u_gap0 (
        .clk(clk), .rst(rst), .in_a(in_a[0]), .in_b(in_b[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]), .bit_valid(bit_valid[0]),
        .first(first[0]), .last(last[0]), .busy(busy[0])
    );

    serial_pair_feeder #(.WIDTH(W), .GAP(2)) u_gap2 (
        .clk(clk), .rst(rst), .in_a(in_a[1]), .in_b(in_b[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1]), .b(b[1]), .bit_valid(bit_valid[1]),
        .first(first[1]), .last(last[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, t, got, exp);
        end
    endtask

    // Expected outputs for cycle t, derived from each word's scheduled start.
    task automatic model_eval(input int i, output logic ea, output logic eb, output logic ebv,
                              output logic ef, output logic el, output logic ebusy,
                              output logic ehold);
        int g, s, e;
        logic [W-1:0] wa, wb;
        g = (i == 0) ? 0 : 2;
        ea = 0; eb = 0; ebv = 0; ef = 0; el = 0; ebusy = 0; ehold = 0;
        foreach (sq[k]) begin
            if (sq[k].inst == i) begin
                s  = sq[k].start;
                e  = s + W - 1;
                wa = sq[k].wa;
                wb = sq[k].wb;
                if (t >= s && t <= e) begin
                    ebv = 1; ebusy = 1;
                    ea = wa[W-1-(t-s)];
                    eb = wb[W-1-(t-s)];
                    ef = (t == s);
                    el = (t == e);
                end
                if (t > sq[k].acc && t < s) begin
                    ehold = 1; ebusy = 1;
                end
                if (t > e && t <= e + g) ebusy = 1;
            end
        end
    endtask

    task automatic step(input logic r, input logic [1:0] en);
        logic ea, eb, ebv, ef, el, ebusy, er;
        logic eh [2];
        string p;
        int g, s;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            model_eval(i, ea, eb, ebv, ef, el, ebusy, eh[i]);
            p = (i == 0) ? "gap0" : "gap2";
            check({p, ".a"},         W'(a[i]),         W'(ea));
            check({p, ".b"},         W'(b[i]),         W'(eb));
            check({p, ".bit_valid"}, W'(bit_valid[i]), W'(ebv));
            check({p, ".first"},     W'(first[i]),     W'(ef));
            check({p, ".last"},      W'(last[i]),      W'(el));
            check({p, ".busy"},      W'(busy[i]),      W'(ebusy));
        end
        rst = r;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0;
            if (cur[i] < src.size()) begin
                {in_a[i], in_b[i]} = src[cur[i]];
                in_valid[i] = en[i];
            end else begin
                in_a[i] = $urandom;
                in_b[i] = $urandom;
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            p  = (i == 0) ? "gap0" : "gap2";
            er = !r && !eh[i];
            check({p, ".in_ready"}, W'(in_ready[i]), W'(er));
            if (!r && in_valid[i] && er) begin
                g = (i == 0) ? 0 : 2;
                s = (t + 1 > prev_end[i] + 1 + g) ? t + 1 : prev_end[i] + 1 + g;
                sq.push_back('{i, in_a[i], in_b[i], t, s});
                prev_end[i] = s + W - 1;
                cur[i]++;
            end
        end
        if (r) begin
            sq.delete();
            prev_end[0] = -1000;
            prev_end[1] = -1000;
        end
        while (sq.size() > 0 && sq[0].start + W + 4 < t) void'(sq.pop_front());
        t++;
    endtask

    initial begin
        logic [1:0] en;
        int mx;
        n_tests = 0; n_fail = 0; t = 0;
        cur[0] = 0; cur[1] = 0;
        prev_end[0] = -1000; prev_end[1] = -1000;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; in_a[i] = '0; in_b[i] = '0;
        end
        repeat (2) @(posedge clk);

        // Reset held with in_valid high, then two back-to-back words and idle.
        src.push_back({32'hCA47FDEA, 32'h1964CBE5});
        src.push_back({32'hB4B735C1, 32'h27E88251});
        repeat (3) step(1'b1, 2'b11);
        repeat (80) step(1'b0, 2'b11);
        repeat (30) step(1'b0, 2'b11);

        // Reset in the middle of a word with the next word held.
        src.push_back({32'hCA47FDEA, 32'h1964CBE5});
        src.push_back({32'hB4B735C1, 32'h27E88251});
        repeat (11) step(1'b0, 2'b11);
        step(1'b1, 2'b00);
        src.push_back({32'hF2EA8541, 32'h0F0F1234});
        repeat (45) step(1'b0, 2'b11);

        for (int n = 0; n < 2500; n++) begin
            mx = (cur[0] > cur[1]) ? cur[0] : cur[1];
            while (src.size() < mx + 4) src.push_back({$urandom, $urandom});
            en[0] = ($urandom_range(0, 3) != 0);
            en[1] = ($urandom_range(0, 3) != 0);
            step(($urandom_range(0, 299) == 0), en);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
